// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision field widths, exponent
// bias and the packed float_t layout {sign, exp, frac}.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    // Exponent of a value whose MSB sits at bit 31 of a 32-bit magnitude.
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + 31);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter.
// Ports: a (32-bit operand) -> cnt (0..31, or 32 when a is zero).
module lzc32 (
    input  logic [31:0] a,
    output logic [5:0]  cnt
);

    // Scan upward so the highest set bit makes the final assignment.
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) begin
                cnt = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Pipelined signed int32 -> single-precision converter (fcvt.s.w), RNE.
// Ports: clk, rstn (async low), en (advance), val_in/x1 in; y/val_out out.
// Optional ITOF_INEXACT_EN macro adds the registered 'inexact' flag output.
module itof_pipe
    import fpu_pkg::*;
#(
    parameter int NSTAGE = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        val_in,
    input  logic [31:0] x1,
    output logic [31:0] y,
`ifdef ITOF_INEXACT_EN
    output logic        inexact,
`endif
    output logic        val_out
);

    // Register B plus any trailing pure-delay registers.
    localparam int ND = NSTAGE - 1;

    // Stage 1: sign/magnitude split and leading-zero count.
    logic [31:0] s1_mag;
    logic [5:0]  s1_lz;

    // 0x80000000 negates to itself, which is exactly 2^31 unsigned.
    assign s1_mag = x1[31] ? (~x1 + 32'd1) : x1;

    lzc32 u_lzc (
        .a   (s1_mag),
        .cnt (s1_lz)
    );

    logic        a_sign;
    logic [31:0] a_mag;
    logic [5:0]  a_lz;
    logic        a_val;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_sign <= 1'b0;
            a_mag  <= '0;
            a_lz   <= '0;
            a_val  <= 1'b0;
        end else if (en) begin
            a_sign <= x1[31];
            a_mag  <= s1_mag;
            a_lz   <= s1_lz;
            a_val  <= val_in;
        end
    end

    // Stage 2: normalise, round to nearest even, pack.
    logic [31:0] norm;
    logic        rnd_up;
    logic [23:0] fsum;
    logic        carry;
    logic        zero;
    float_t      res;

    assign norm   = a_mag << a_lz;
    // Only a zero magnitude leaves the normalised MSB clear.
    assign zero   = ~norm[31];
    assign rnd_up = norm[7] & ((|norm[6:0]) | norm[8]);
    // Carry out of the 23-bit fraction equals carry out of {1, frac}.
    assign fsum   = {1'b0, norm[30:8]} + 24'(rnd_up);
    assign carry  = fsum[23];

    always_comb begin
        res = '0;
        if (!zero) begin
            res.sign = a_sign;
            res.exp  = EXP_TOP - {2'b00, a_lz} + {7'd0, carry};
            res.frac = fsum[22:0];
        end
    end

    float_t p_y [ND];
    logic   p_v [ND];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ND; i++) begin
                p_y[i] <= '0;
                p_v[i] <= 1'b0;
            end
        end else if (en) begin
            p_y[0] <= res;
            p_v[0] <= a_val;
            for (int i = 1; i < ND; i++) begin
                p_y[i] <= p_y[i-1];
                p_v[i] <= p_v[i-1];
            end
        end
    end

    assign y       = p_y[ND-1];
    assign val_out = p_v[ND-1];

`ifdef ITOF_INEXACT_EN
    logic p_x [ND];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ND; i++) begin
                p_x[i] <= 1'b0;
            end
        end else if (en) begin
            p_x[0] <= norm[7] | (|norm[6:0]);
            for (int i = 1; i < ND; i++) begin
                p_x[i] <= p_x[i-1];
            end
        end
    end

    assign inexact = p_x[ND-1];
`endif

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: arithmetic reference conversion,
// cycle-level pipeline model, directed, stall, reset and random stimulus.
module tb_itof_pipe;

    localparam int NS = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        val_in;
    logic [31:0] x1;
    logic [31:0] y;
    logic        val_out;
`ifdef ITOF_INEXACT_EN
    logic        inexact;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    itof_pipe #(.NSTAGE(NS)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .val_in  (val_in),
        .x1      (x1),
        .y       (y),
`ifdef ITOF_INEXACT_EN
        .inexact (inexact),
`endif
        .val_out (val_out)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %08h expected %08h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference: exact integer arithmetic, round half to even.
    // Returns {inexact, float bits}.
    function automatic logic [32:0] ref_cvt(input logic [31:0] x);
        longint v, m, q, rem, half;
        int p, sh, e;
        logic ix;
        v  = longint'($signed(x));
        m  = (v < 0) ? -v : v;
        ix = 1'b0;
        if (m == 0) return 33'd0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        e = p + 127;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            ix   = (rem != 0);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e++;
            end
        end
        return {ix, x[31], 8'(e), 23'(q)};
    endfunction

    // Pipeline model: NS slots that shift whenever en is high.
    logic [32:0] m_d [NS];
    logic        m_v [NS];

    initial begin
        for (int i = 0; i < NS; i++) begin
            m_d[i] = '0;
            m_v[i] = 1'b0;
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NS; i++) begin
                m_d[i] = '0;
                m_v[i] = 1'b0;
            end
        end else if (en) begin
            for (int i = NS - 1; i > 0; i--) begin
                m_d[i] = m_d[i-1];
                m_v[i] = m_v[i-1];
            end
            m_d[0] = ref_cvt(x1);
            m_v[0] = val_in;
        end
    end

    // Every cycle: y (data path is deterministic) and val_out vs model.
    logic [31:0] got [$];
    logic [32:0] exp_d;

    always @(negedge clk) begin
        exp_d = m_d[NS-1];
        chk("y", y, exp_d[31:0]);
        chk("val_out", {31'd0, val_out}, {31'd0, m_v[NS-1]});
`ifdef ITOF_INEXACT_EN
        chk("inexact", {31'd0, inexact}, {31'd0, exp_d[32]});
`endif
        if (val_out && en && rstn) got.push_back(y);
    end

    task automatic step(input logic e, input logic v, input logic [31:0] x);
        en     = e;
        val_in = v;
        x1     = x;
        @(posedge clk);
        #1;
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0);
    endtask

    // Single conversion with literal expectation and latency check.
    task automatic dir(input string name, input logic [31:0] x,
                       input logic [31:0] exp, input logic ix);
        bubbles(NS);
        step(1'b1, 1'b1, x);
        chk({name, "_early"}, {31'd0, val_out}, 32'd0);
        for (int i = 0; i < NS - 1; i++) step(1'b1, 1'b0, 32'd0);
        chk(name, y, exp);
        chk({name, "_val"}, {31'd0, val_out}, 32'd1);
`ifdef ITOF_INEXACT_EN
        chk({name, "_inx"}, {31'd0, inexact}, {31'd0, ix});
`else
        if (ix === 1'bx) $display("unreachable");
`endif
    endtask

    logic [32:0] r;
    logic [31:0] hold_y;
    logic        hold_v;
    int          sel;

    initial begin
        rstn   = 1'b0;
        en     = 1'b0;
        val_in = 1'b0;
        x1     = 32'd0;

        r = ref_cvt(32'd1);          chk("model_one", r[31:0], 32'h3F800000);
        r = ref_cvt(32'h7FFFFFFF);   chk("model_max", r[31:0], 32'h4F000000);
        r = ref_cvt(32'd16777223);   chk("model_tie", r[31:0], 32'h4B800004);
        r = ref_cvt(32'hFFFFFFFF);   chk("model_neg", r[31:0], 32'hBF800000);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", y, 32'd0);
        chk("rst_val", {31'd0, val_out}, 32'd0);
        rstn = 1'b1;

        dir("one",     32'd1,          32'h3F800000, 1'b0);
        dir("m_one",   32'hFFFFFFFF,   32'hBF800000, 1'b0);
        dir("zero",    32'd0,          32'h00000000, 1'b0);
        dir("min",     32'h80000000,   32'hCF000000, 1'b0);
        dir("max",     32'h7FFFFFFF,   32'h4F000000, 1'b1);
        dir("tie1",    32'd16777217,   32'h4B800000, 1'b1);
        dir("tie3",    32'd16777219,   32'h4B800002, 1'b1);
        dir("tie5",    32'd16777221,   32'h4B800002, 1'b1);
        dir("tie7",    32'd16777223,   32'h4B800004, 1'b1);

        // Stall mid-stream: outputs freeze, no loss or duplication.
        bubbles(NS);
        got.delete();
        step(1'b1, 1'b1, 32'd5);
        step(1'b1, 1'b1, 32'd6);
        hold_y = y;
        hold_v = val_out;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'd99);
            chk("stall_y", y, hold_y);
            chk("stall_v", {31'd0, val_out}, {31'd0, hold_v});
        end
        step(1'b1, 1'b1, 32'd7);
        bubbles(NS + 1);
        chk("stall_cnt", got.size(), 32'd3);
        if (got.size() == 3) begin
            chk("stall_0", got[0], 32'h40A00000);
            chk("stall_1", got[1], 32'h40C00000);
            chk("stall_2", got[2], 32'h40E00000);
        end

        // Asynchronous reset with valids in flight.
        for (int i = 0; i < NS + 1; i++) step(1'b1, 1'b1, 32'd1000 + i);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_y", y, 32'd0);
        chk("arst_val", {31'd0, val_out}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < NS + 2; i++) begin
            step(1'b1, 1'b0, 32'd0);
            chk("no_stale", {31'd0, val_out}, 32'd0);
        end

        // Back-to-back sweep around the rounding boundary and zero.
        for (int i = 0; i < 600; i++) step(1'b1, 1'b1, 32'd16777000 + i);
        for (int i = -300; i < 300; i++) step(1'b1, 1'b1, 32'(i));

        // Randomised traffic with bubbles and stalls.
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: x1 = 32'h80000000;
                1: x1 = 32'h7FFFFFFF - $urandom_range(0, 255);
                2: x1 = 32'd16777216 + $urandom_range(0, 15);
                3: x1 = 32'($signed($urandom_range(0, 64)) - 32);
                default: x1 = $urandom;
            endcase
            step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 90, x1);
        end
        bubbles(NS + 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
